// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 streaming FFT stage scheduler.
package fft_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } fft_sched_state_t;

    // Number of butterfly stages for an n-point transform.
    function automatic int unsigned num_stages(input int unsigned n);
        return $clog2(n);
    endfunction

    // Advance count at which stage i first has valid data: n - (n >> i).
    function automatic int unsigned stage_threshold(input int unsigned n, input int unsigned i);
        return n - (n >> i);
    endfunction

endpackage

// File: rtl/fft_sched_counter.sv
// Small up-counter with synchronous clear and optional saturation at all-ones.
module fft_sched_counter #(
    parameter int unsigned Width    = 4,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Clear wins over increment; saturating instances hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(Saturate && (&cnt_q))) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fft_stage_scheduler.sv
// Fill/steady/drain scheduler driving per-stage enables of a radix-2 SDF FFT.
// Optional performance counters are built when FFT_SCHED_PERF_EN is defined.
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned NUM_STAGES = num_stages(N)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic                  s_last_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [NUM_STAGES-1:0] stage_en_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  err_frame_o
`ifdef FFT_SCHED_PERF_EN
   ,output logic [31:0]           perf_stall_cnt_o,
    output logic [15:0]           perf_frames_o
`endif
);

    localparam int unsigned     CntW   = $clog2(N);
    localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

    fft_sched_state_t state_q, state_d;
    logic             err_q, err_d;

    logic [CntW-1:0] fill_cnt, drain_cnt, in_cnt, out_cnt;
    logic            in_drain, src_ok, out_phase, advance, accept, out_hs;
    logic            drain_exit, ctr_clr;

    assign in_drain   = (state_q == StDrain);
    assign src_ok     = reset_ni && ((s_valid_i && !in_drain) || in_drain);
    // fill_cnt saturates at N-1, so ">= N-1" reduces to equality.
    assign out_phase  = (fill_cnt == CntMax) && (!in_drain || (drain_cnt != CntMax));
    assign advance    = src_ok && (!out_phase || m_ready_i);
    assign accept     = advance && !in_drain;
    assign out_hs     = advance && out_phase;
    assign drain_exit = in_drain && (drain_cnt == CntMax);
    assign ctr_clr    = !reset_ni || drain_exit;

    assign s_ready_o    = reset_ni && !in_drain;
    assign m_valid_o    = src_ok && out_phase;
    assign frame_done_o = out_hs && (out_cnt == CntMax);
    assign busy_o       = reset_ni && (state_q != StIdle);
    assign err_frame_o  = err_q;

    // Stage i runs once the pipe holds T_i samples and stops after drain index T_{i+1}-1.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        localparam logic [CntW-1:0] ThrHi = CntW'(stage_threshold(N, gi + 1));
        logic lo_ok;
        if (gi == 0) begin : g_first
            assign lo_ok = 1'b1;
        end else begin : g_rest
            localparam logic [CntW-1:0] ThrLo = CntW'(stage_threshold(N, gi));
            assign lo_ok = (fill_cnt >= ThrLo);
        end
        assign stage_en_o[gi] = advance && lo_ok && (!in_drain || (drain_cnt < ThrHi));
    end

    fft_sched_counter #(.Width(CntW), .Saturate(1'b1)) u_fill_cnt (
        .clk_i (clk_i),
        .clr_i (ctr_clr),
        .inc_i (advance),
        .cnt_o (fill_cnt)
    );

    fft_sched_counter #(.Width(CntW), .Saturate(1'b0)) u_drain_cnt (
        .clk_i (clk_i),
        .clr_i (ctr_clr),
        .inc_i (advance && in_drain),
        .cnt_o (drain_cnt)
    );

    fft_sched_counter #(.Width(CntW), .Saturate(1'b0)) u_in_cnt (
        .clk_i (clk_i),
        .clr_i (ctr_clr),
        .inc_i (accept),
        .cnt_o (in_cnt)
    );

    fft_sched_counter #(.Width(CntW), .Saturate(1'b0)) u_out_cnt (
        .clk_i (clk_i),
        .clr_i (ctr_clr),
        .inc_i (out_hs),
        .cnt_o (out_cnt)
    );

    // Next state and sticky framing error.
    always_comb begin
        state_d = state_q;
        err_d   = err_q || (accept && s_last_i && (in_cnt != CntMax));
        unique case (state_q)
            StIdle:  if (accept) state_d = s_last_i ? StDrain : StRun;
            StRun:   if (accept && s_last_i) state_d = StDrain;
            StDrain: if (drain_exit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state and error flag registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef FFT_SCHED_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_frames_q;

    // Output-stall cycles and completed frames, both free-running.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            perf_stall_q  <= '0;
            perf_frames_q <= '0;
        end else begin
            if (m_valid_o && !m_ready_i) perf_stall_q <= perf_stall_q + 32'd1;
            if (frame_done_o) perf_frames_q <= perf_frames_q + 16'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_frames_o    = perf_frames_q;
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler with N=16.
module tb_fft_stage_scheduler;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n, s_valid, s_last, m_ready;
    logic       s_ready, m_valid, frame_done, busy, err_frame;
    logic [3:0] stage_en;
`ifdef FFT_SCHED_PERF_EN
    logic [31:0] perf_stall;
    logic [15:0] perf_frames;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_stage_scheduler #(.N(N)) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_last_i     (s_last),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .stage_en_o   (stage_en),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .err_frame_o  (err_frame)
`ifdef FFT_SCHED_PERF_EN
       ,.perf_stall_cnt_o (perf_stall),
        .perf_frames_o    (perf_frames)
`endif
    );

    typedef struct {
        logic       rst;
        logic       sv;
        logic       sl;
        logic       mr;
        logic [3:0] en;
        logic       srdy;
        logic       mv;
        logic       bsy;
        logic       fd;
        logic       err;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mkv(input logic rst, input logic sv, input logic sl, input logic mr,
                                 input logic [3:0] en, input logic srdy, input logic mv,
                                 input logic bsy, input logic fd, input logic err);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sl = sl; v.mr = mr;
        v.en = en; v.srdy = srdy; v.mv = mv; v.bsy = bsy; v.fd = fd; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    // Drives one stream of nsamp samples and records when events occur in advance index terms.
    task automatic run_frame(input string tag, input int nsamp, input int gap_len,
                             input int stall_len, input int abort_dix, input logic exp_err,
                             input int exp_outs, input int exp_fds);
        int  adv, dix, acc, g4, g10, stall_left, outs, fds, fd_at, first_mv;
        int  first_en[4];
        int  last_en[4];
        int  first_exp[4];
        int  last_exp[4];
        bit  draining, done, aborted, outp, adv_exp, sv, mr;
        first_exp = '{0, 8, 12, 14};
        last_exp  = '{7, 11, 13, 14};
        adv = 0; dix = 0; acc = 0; g4 = 0; g10 = 0; outs = 0; fds = 0; fd_at = -1;
        first_mv = -1; stall_left = stall_len;
        draining = 0; done = 0; aborted = 0;
        for (int i = 0; i < 4; i++) begin
            first_en[i] = -1;
            last_en[i]  = -1;
        end
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            outp = (adv >= N - 1) && !(draining && dix >= N - 1);
            if (draining && dix == abort_dix) begin
                rst_n = 1'b0; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
                @(negedge clk);
                check({tag, "/rst_en"}, stage_en, 0);
                check({tag, "/rst_sready"}, s_ready, 0);
                check({tag, "/rst_mvalid"}, m_valid, 0);
                check({tag, "/rst_busy"}, busy, 0);
                check({tag, "/rst_fdone"}, frame_done, 0);
                tick();
                rst_n = 1'b1; s_valid = 1'b0;
                @(negedge clk);
                check({tag, "/post_busy"}, busy, 0);
                check({tag, "/post_sready"}, s_ready, 1);
                check({tag, "/post_en"}, stage_en, 0);
                check({tag, "/post_err"}, err_frame, 0);
                tick();
                aborted = 1; done = 1;
            end else begin
                sv = !draining;
                if (sv && gap_len > 0 && acc == 4 && g4 < gap_len) begin
                    sv = 0; g4++;
                end else if (sv && gap_len > 0 && acc == 10 && g10 < gap_len) begin
                    sv = 0; g10++;
                end
                mr = 1;
                if (outp && stall_left > 0) begin
                    mr = 0; stall_left--;
                end
                s_valid = sv; s_last = sv && (acc == nsamp - 1); m_ready = mr;
                @(negedge clk);
                adv_exp = (draining || sv) && (!outp || mr);
                check({tag, "/mvalid"}, m_valid, (draining || sv) && outp);
                check({tag, "/sready"}, s_ready, !draining);
                check({tag, "/busy"}, busy, draining || acc > 0);
                if (!adv_exp) check({tag, "/hold_en"}, stage_en, 0);
                for (int i = 0; i < 4; i++) begin
                    if (stage_en[i]) begin
                        if (first_en[i] < 0) first_en[i] = adv;
                        if (draining) last_en[i] = dix;
                    end
                end
                if (m_valid && first_mv < 0) first_mv = adv;
                if (m_valid && mr) outs++;
                if (frame_done) begin
                    fds++;
                    fd_at = outs - 1;
                end
                tick();
                if (adv_exp) begin
                    adv++;
                    if (draining) begin
                        dix++;
                        if (dix >= N) done = 1;
                    end else begin
                        if (s_last) draining = 1;
                        acc++;
                    end
                end
            end
        end
        check({tag, "/finished"}, done, 1);
        if (!aborted) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s/first_en%0d", tag, i), first_en[i], first_exp[i]);
                check($sformatf("%s/last_en%0d", tag, i), last_en[i], last_exp[i]);
            end
            check({tag, "/first_mvalid"}, first_mv, N - 1);
            check({tag, "/outputs"}, outs, exp_outs);
            check({tag, "/frame_dones"}, fds, exp_fds);
            if (exp_fds > 0) check({tag, "/fdone_index"}, fd_at, N - 1);
            s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
            @(negedge clk);
            check({tag, "/end_busy"}, busy, 0);
            check({tag, "/end_sready"}, s_ready, 1);
            check({tag, "/end_en"}, stage_en, 0);
            check({tag, "/end_err"}, err_frame, exp_err);
            tick();
        end
    endtask

    initial begin
        // Single-sample stream straight out of reset, cycle by cycle.
        tbl[0] = mkv(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
        tbl[1] = mkv(1, 1, 1, 1, 4'b0001, 1, 0, 0, 0, 0);
        for (int k = 0; k <= 6; k++) tbl[2 + k] = mkv(1, 0, 0, 1, 4'b0001, 0, 0, 1, 0, 1);
        tbl[9]  = mkv(1, 0, 0, 1, 4'b0011, 0, 0, 1, 0, 1);
        tbl[10] = mkv(1, 0, 0, 1, 4'b0010, 0, 0, 1, 0, 1);
        tbl[11] = mkv(1, 0, 0, 1, 4'b0010, 0, 0, 1, 0, 1);
        tbl[12] = mkv(1, 0, 0, 1, 4'b0010, 0, 0, 1, 0, 1);
        tbl[13] = mkv(1, 0, 0, 1, 4'b0110, 0, 0, 1, 0, 1);
        tbl[14] = mkv(1, 0, 0, 1, 4'b0100, 0, 0, 1, 0, 1);
        tbl[15] = mkv(1, 0, 0, 1, 4'b1100, 0, 0, 1, 0, 1);
        tbl[16] = mkv(1, 0, 0, 1, 4'b1000, 0, 1, 1, 0, 1);
        tbl[17] = mkv(1, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 1);
        tbl[18] = mkv(1, 0, 0, 1, 4'b0000, 1, 0, 0, 0, 1);

        rst_n = 1'b0; s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            rst_n = tbl[i].rst; s_valid = tbl[i].sv; s_last = tbl[i].sl; m_ready = tbl[i].mr;
            @(negedge clk);
            check($sformatf("vec%0d/stage_en", i), stage_en, tbl[i].en);
            check($sformatf("vec%0d/s_ready", i), s_ready, tbl[i].srdy);
            check($sformatf("vec%0d/m_valid", i), m_valid, tbl[i].mv);
            check($sformatf("vec%0d/busy", i), busy, tbl[i].bsy);
            check($sformatf("vec%0d/frame_done", i), frame_done, tbl[i].fd);
            check($sformatf("vec%0d/err_frame", i), err_frame, tbl[i].err);
            tick();
        end

        do_reset();
        @(negedge clk);
        check("reset/err_cleared", err_frame, 0);
        tick();

        run_frame("full", 16, 0, 0, -1, 1'b0, 16, 1);
        run_frame("stall", 16, 0, 5, -1, 1'b0, 16, 1);
        run_frame("gaps", 16, 3, 0, -1, 1'b0, 16, 1);
        run_frame("short", 6, 0, 0, -1, 1'b1, 6, 0);
        run_frame("abort", 6, 0, 0, 4, 1'b0, 0, 0);
        run_frame("after_abort", 16, 0, 0, -1, 1'b0, 16, 1);

`ifdef FFT_SCHED_PERF_EN
        do_reset();
        run_frame("perf1", 16, 0, 3, -1, 1'b0, 16, 1);
        run_frame("perf2", 16, 0, 4, -1, 1'b0, 16, 1);
        @(negedge clk);
        check("perf/stall_cnt", perf_stall, 7);
        check("perf/frames", perf_frames, 2);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
